// File: rtl/nf10_axis_capture_pkg.sv
// Shared types, counter widths and helpers for the nf10 AXI4-Stream capture sink.
package nf10_axis_capture_pkg;

  localparam int PKT_CNT_W       = 32;
  localparam int BEAT_CNT_W      = 32;
  localparam int BYTE_CNT_W      = 48;
  localparam int POPCNT_MAX_W    = 128;
  localparam int CAP_LEN_W_DEF   = 16;
  localparam int CAP_TUSER_W_DEF = 128;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } cap_state_e;

  // Layout of one capture entry in the default configuration: {len, tuser}.
  typedef struct packed {
    logic [CAP_LEN_W_DEF-1:0]   len;
    logic [CAP_TUSER_W_DEF-1:0] tuser;
  } cap_entry_t;

  function automatic logic [7:0] popcount(input logic [POPCNT_MAX_W-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < POPCNT_MAX_W; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/nf10_capture_fifo.sv
// First-word-fall-through capture FIFO; pushes against a full FIFO are dropped
// and flagged in a sticky overflow bit.
module nf10_capture_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             clr_ovf_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             overflow_q;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A same-cycle pop frees the head slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full || do_pop);
  assign drop    = push_i && full && !do_pop;

  assign rd_data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_o = overflow_q;

  // NOTE: the storage array is deliberately not reset; the pointers alone define
  // which entries are valid, and an empty FIFO forces the read port to zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (clr_ovf_i)  overflow_q <= 1'b0;
      else if (drop)  overflow_q <= 1'b1;
    end
  end

endmodule

// File: rtl/nf10_axis_capture_sink.sv
// AXI4-Stream sink with programmable back-pressure, statistics and a per-packet
// {len, tuser} capture FIFO. Define NF10_AXIS_CAPTURE_PROTOCOL_CHECK_EN for the protocol checker.
module nf10_axis_capture_sink
  import nf10_axis_capture_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = CAP_TUSER_W_DEF,
  parameter int C_FIFO_DEPTH         = 16,
  parameter int C_LEN_WIDTH          = CAP_LEN_W_DEF
) (
  input  logic                                        aclk,
  input  logic                                        areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]            s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]             s_axis_tuser,
  input  logic                                        s_axis_tvalid,
  output logic                                        s_axis_tready,
  input  logic                                        s_axis_tlast,
  input  logic [7:0]                                  cfg_stall_period,
  input  logic                                        stat_clear,
  output logic [PKT_CNT_W-1:0]                        stat_pkt_count,
  output logic [BEAT_CNT_W-1:0]                       stat_beat_count,
  output logic [BYTE_CNT_W-1:0]                       stat_byte_count,
  input  logic                                        cap_rd_en,
  output logic [C_LEN_WIDTH+C_S_AXIS_TUSER_WIDTH-1:0] cap_rd_data,
  output logic                                        cap_empty,
  output logic                                        cap_overflow,
  output logic                                        proto_err
);

  localparam int STRB_W  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int ENTRY_W = C_LEN_WIDTH + C_S_AXIS_TUSER_WIDTH;
  localparam int SUM_W   = C_LEN_WIDTH + 9;
  localparam logic [C_LEN_WIDTH-1:0] LEN_MAX = '1;

  cap_state_e                      state_q;
  logic [C_LEN_WIDTH-1:0]          len_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_q;
  logic [7:0]                      thr_cnt_q, thr_cnt_d;
  logic                            tready_q, tready_d;
  logic                            thr_hit;
  logic [PKT_CNT_W-1:0]            pkt_cnt_q;
  logic [BEAT_CNT_W-1:0]           beat_cnt_q;
  logic [BYTE_CNT_W-1:0]           byte_cnt_q;

  logic                            accept;
  logic                            pkt_done;
  logic [POPCNT_MAX_W-1:0]         strb_ext;
  logic [7:0]                      beat_bytes;
  logic [C_LEN_WIDTH-1:0]          len_base;
  logic [SUM_W-1:0]                len_sum;
  logic [C_LEN_WIDTH-1:0]          len_next;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_sel;
  logic [ENTRY_W-1:0]              push_entry;

  // Throttle: tready drops for exactly one cycle out of every cfg_stall_period.
  assign thr_hit   = (cfg_stall_period != 8'd0) && (thr_cnt_q == cfg_stall_period - 8'd1);
  assign thr_cnt_d = thr_hit ? 8'd0 : thr_cnt_q + 8'd1;
  assign tready_d  = !thr_hit;

  assign accept     = s_axis_tvalid && tready_q;
  assign pkt_done   = accept && s_axis_tlast;
  assign strb_ext   = POPCNT_MAX_W'(s_axis_tstrb);
  assign beat_bytes = popcount(strb_ext);

  assign len_base   = (state_q == ST_IN_PKT) ? len_q : '0;
  assign len_sum    = SUM_W'(len_base) + SUM_W'(beat_bytes);
  assign len_next   = (len_sum > SUM_W'(LEN_MAX)) ? LEN_MAX : len_sum[C_LEN_WIDTH-1:0];
  assign tuser_sel  = (state_q == ST_IDLE) ? s_axis_tuser : tuser_q;
  assign push_entry = {len_next, tuser_sel};

  // NOTE: every register here uses non-blocking assignment so all of them sample
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      thr_cnt_q <= '0;
      tready_q  <= 1'b0;
    end else begin
      thr_cnt_q <= thr_cnt_d;
      tready_q  <= tready_d;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      tuser_q <= '0;
    end else if (accept) begin
      len_q <= len_next;
      if (state_q == ST_IDLE) tuser_q <= s_axis_tuser;
      state_q <= s_axis_tlast ? ST_IDLE : ST_IN_PKT;
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
      byte_cnt_q <= '0;
    end else if (stat_clear) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      if (pkt_done) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (accept) begin
        beat_cnt_q <= beat_cnt_q + 32'd1;
        byte_cnt_q <= byte_cnt_q + BYTE_CNT_W'(beat_bytes);
      end
    end
  end

  assign s_axis_tready   = tready_q;
  assign stat_pkt_count  = pkt_cnt_q;
  assign stat_beat_count = beat_cnt_q;
  assign stat_byte_count = byte_cnt_q;

  nf10_capture_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk         (aclk),
    .rst         (areset),
    .push_i      (pkt_done),
    .push_data_i (push_entry),
    .pop_i       (cap_rd_en),
    .clr_ovf_i   (stat_clear),
    .rd_data_o   (cap_rd_data),
    .empty_o     (cap_empty),
    .overflow_o  (cap_overflow)
  );

`ifdef NF10_AXIS_CAPTURE_PROTOCOL_CHECK_EN
  logic                            stalled_q;
  logic                            proto_err_q;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  hold_tdata_q;
  logic [STRB_W-1:0]               hold_tstrb_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] hold_tuser_q;
  logic                            hold_tlast_q;
  logic                            hold_viol;
  logic                            strb_viol;

  // After a stalled cycle the source must keep the same beat presented.
  assign hold_viol = stalled_q && (!s_axis_tvalid ||
                                   (s_axis_tdata != hold_tdata_q) ||
                                   (s_axis_tstrb != hold_tstrb_q) ||
                                   (s_axis_tuser != hold_tuser_q) ||
                                   (s_axis_tlast != hold_tlast_q));
  assign strb_viol = accept && (s_axis_tstrb == '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stalled_q    <= 1'b0;
      proto_err_q  <= 1'b0;
      hold_tdata_q <= '0;
      hold_tstrb_q <= '0;
      hold_tuser_q <= '0;
      hold_tlast_q <= 1'b0;
    end else begin
      stalled_q    <= s_axis_tvalid && !tready_q;
      hold_tdata_q <= s_axis_tdata;
      hold_tstrb_q <= s_axis_tstrb;
      hold_tuser_q <= s_axis_tuser;
      hold_tlast_q <= s_axis_tlast;
      if (stat_clear)                  proto_err_q <= 1'b0;
      else if (hold_viol || strb_viol) proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;
`else
  // tdata is only inspected by the protocol checker.
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata;
  assign proto_err    = 1'b0;
`endif

endmodule

// File: tb/tb_nf10_axis_capture_sink.sv
// Directed bench for nf10_axis_capture_sink with a queue-based reference model
// checked every cycle on the falling clock edge.
module tb_nf10_axis_capture_sink;
  import nf10_axis_capture_pkg::*;

  localparam int DW    = 256;
  localparam int SW    = DW / 8;
  localparam int UW    = 128;
  localparam int LW    = 16;
  localparam int DEPTH = 16;
  localparam int LMAX  = (1 << LW) - 1;

`ifdef NF10_AXIS_CAPTURE_PROTOCOL_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  localparam logic [UW-1:0] U1  = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
  localparam logic [UW-1:0] U1B = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
  localparam logic [UW-1:0] U2  = 128'h2222_0000_0000_0000_0000_0000_0000_0002;
  localparam logic [UW-1:0] U3  = 128'h3333_0000_0000_0000_0000_0000_0000_0003;
  localparam logic [UW-1:0] U5  = 128'h5555_0000_0000_0000_0000_0000_0000_0005;
  localparam logic [UW-1:0] U6  = 128'h6666_0000_0000_0000_0000_0000_0000_0006;
  localparam logic [UW-1:0] U7  = 128'h7777_0000_0000_0000_0000_0000_0000_0007;
  localparam logic [UW-1:0] U8  = 128'h8888_0000_0000_0000_0000_0000_0000_0008;
  localparam logic [UW-1:0] U9  = 128'h9999_0000_0000_0000_0000_0000_0000_0009;
  localparam logic [UW-1:0] U10 = 128'haaaa_0000_0000_0000_0000_0000_0000_000a;

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic [DW-1:0]    s_axis_tdata = '0;
  logic [SW-1:0]    s_axis_tstrb = '0;
  logic [UW-1:0]    s_axis_tuser = '0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tready;
  logic             s_axis_tlast = 1'b0;
  logic [7:0]       cfg_stall_period = 8'd0;
  logic             stat_clear = 1'b0;
  logic [31:0]      stat_pkt_count;
  logic [31:0]      stat_beat_count;
  logic [47:0]      stat_byte_count;
  logic             cap_rd_en = 1'b0;
  logic [LW+UW-1:0] cap_rd_data;
  logic             cap_empty;
  logic             cap_overflow;
  logic             proto_err;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  nf10_axis_capture_sink #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .C_FIFO_DEPTH         (DEPTH),
    .C_LEN_WIDTH          (LW)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tstrb     (s_axis_tstrb),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .cfg_stall_period (cfg_stall_period),
    .stat_clear       (stat_clear),
    .stat_pkt_count   (stat_pkt_count),
    .stat_beat_count  (stat_beat_count),
    .stat_byte_count  (stat_byte_count),
    .cap_rd_en        (cap_rd_en),
    .cap_rd_data      (cap_rd_data),
    .cap_empty        (cap_empty),
    .cap_overflow     (cap_overflow),
    .proto_err        (proto_err)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: counters, current packet and the capture queue.
  int unsigned m_pkt;
  int unsigned m_beat;
  logic [47:0] m_byte;
  bit          m_in_pkt;
  int          m_len;
  logic [UW-1:0] m_tuser;
  cap_entry_t  m_q[$];
  bit          m_ovf;
  bit          m_perr;
`ifdef NF10_AXIS_CAPTURE_PROTOCOL_CHECK_EN
  bit            m_stalled;
  logic [DW-1:0] p_data;
  logic [SW-1:0] p_strb;
  logic [UW-1:0] p_user;
  logic          p_last;
`endif

  task automatic model_reset();
    m_pkt = 0; m_beat = 0; m_byte = '0; m_in_pkt = 0; m_len = 0; m_tuser = '0;
    m_q.delete(); m_ovf = 0; m_perr = 0;
`ifdef NF10_AXIS_CAPTURE_PROTOCOL_CHECK_EN
    m_stalled = 0; p_data = '0; p_strb = '0; p_user = '0; p_last = 0;
`endif
  endtask

  task automatic model_compare();
    cap_entry_t head;
    head = '0;
    if (m_q.size() != 0) head = m_q[0];
    check("pkt_count", stat_pkt_count, m_pkt);
    check("beat_count", stat_beat_count, m_beat);
    check("byte_count", stat_byte_count, m_byte);
    check("cap_empty", cap_empty, m_q.size() == 0);
    check("cap_rd_data", cap_rd_data, head);
    check("cap_overflow", cap_overflow, m_ovf);
    check("proto_err", proto_err, m_perr);
  endtask

  task automatic model_step();
    bit acc, push, pop;
    int nb;
    cap_entry_t e;
    acc  = s_axis_tvalid && s_axis_tready;
    nb   = $countones(s_axis_tstrb);
    push = 0;
    e    = '0;
    if (acc) begin
      m_beat++;
      m_byte = m_byte + 48'(nb);
      if (!m_in_pkt) begin
        m_len   = 0;
        m_tuser = s_axis_tuser;
      end
      m_len = m_len + nb;
      if (m_len > LMAX) m_len = LMAX;
      if (s_axis_tlast) begin
        push     = 1;
        e.len    = LW'(m_len);
        e.tuser  = m_tuser;
        m_in_pkt = 0;
        m_pkt++;
      end else begin
        m_in_pkt = 1;
      end
    end
    pop = cap_rd_en && (m_q.size() > 0);
    if (push && m_q.size() == DEPTH && !pop) begin
      m_ovf = 1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(e);
    end
`ifdef NF10_AXIS_CAPTURE_PROTOCOL_CHECK_EN
    if (m_stalled && (!s_axis_tvalid || s_axis_tdata != p_data || s_axis_tstrb != p_strb ||
                      s_axis_tuser != p_user || s_axis_tlast != p_last)) m_perr = 1;
    if (acc && s_axis_tstrb == '0) m_perr = 1;
    m_stalled = s_axis_tvalid && !s_axis_tready;
    p_data = s_axis_tdata; p_strb = s_axis_tstrb; p_user = s_axis_tuser; p_last = s_axis_tlast;
`endif
    if (stat_clear) begin
      m_pkt = 0; m_beat = 0; m_byte = '0; m_ovf = 0; m_perr = 0;
    end
  endtask

  always @(negedge aclk) begin
    if (areset) begin
      model_reset();
    end else begin
      model_compare();
      model_step();
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Present one beat and hold it until the sink accepts it.
  task automatic beat(input logic [DW-1:0] d, input logic [SW-1:0] st,
                      input logic [UW-1:0] u, input logic l);
    bit acc;
    int n;
    acc = 0;
    n   = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tstrb = st;
    s_axis_tuser  = u;    s_axis_tlast = l;
    while (!acc && n < 300) begin
      @(negedge aclk);
      acc = s_axis_tready;
      step();
      n++;
    end
    check("beat_accepted", acc, 1'b1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic rd_pulse();
    cap_rd_en = 1'b1;
    step();
    cap_rd_en = 1'b0;
  endtask

  task automatic clr_pulse();
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
  endtask

  int tb_lows;
  int tb_accs;
  int tb_last_low;
  int tb_bad_gap;

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    check("tready_first_cycle", s_axis_tready, 1'b0);
    check("rst_pkt", stat_pkt_count, 32'd0);
    check("rst_byte", stat_byte_count, 48'd0);
    check("rst_empty", cap_empty, 1'b1);
    check("rst_rd_data", cap_rd_data, '0);
    check("rst_ovf", cap_overflow, 1'b0);
    check("rst_perr", proto_err, 1'b0);
    step();
    check("tready_second_cycle", s_axis_tready, 1'b1);

    // Two full 32-byte beats form one 64-byte packet.
    beat(256'ha5, '1, U1, 1'b0);
    beat(256'h5a, '1, U1B, 1'b1);
    check("t1_pkt", stat_pkt_count, 32'd1);
    check("t1_beat", stat_beat_count, 32'd2);
    check("t1_byte", stat_byte_count, 48'd64);
    check("t1_head", cap_rd_data, {16'd64, U1});
    rd_pulse();
    check("t1_empty_after_pop", cap_empty, 1'b1);

    // Single 4-byte beat with tlast.
    beat(256'h1234, 32'h0000_000f, U2, 1'b1);
    check("t2_head", cap_rd_data, {16'd4, U2});
    check("t2_byte", stat_byte_count, 48'd68);
    rd_pulse();

    // Throttle period 4 under continuous valid.
    cfg_stall_period = 8'd4;
    idle(260);
    s_axis_tvalid = 1'b1; s_axis_tdata = 256'h33; s_axis_tstrb = '1;
    s_axis_tuser  = U3;   s_axis_tlast = 1'b0;
    tb_lows = 0; tb_accs = 0; tb_last_low = -1; tb_bad_gap = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        tb_accs++;
      end else begin
        if (tb_last_low >= 0 && (i - tb_last_low) != 4) tb_bad_gap++;
        tb_last_low = i;
        tb_lows++;
      end
      step();
    end
    check("t3_accepted", tb_accs, 30);
    check("t3_stalls", tb_lows, 10);
    check("t3_stall_spacing", tb_bad_gap, 0);
    beat(256'h33, '1, U3, 1'b0);
    beat(256'h33, '1, U3, 1'b1);
    check("t3_beat_total", stat_beat_count, 32'd35);
    check("t3_byte_total", stat_byte_count, 48'd1092);
    check("t3_head", cap_rd_data, {16'd1024, U3});
    rd_pulse();
    cfg_stall_period = 8'd0;
    idle(2);

    // DEPTH+2 one-beat packets without reads: two dropped.
    for (int i = 0; i < DEPTH + 2; i++) begin
      beat(DW'(i), (SW'(1) << (i + 1)) - SW'(1), UW'(i + 200), 1'b1);
    end
    check("t4_pkt", stat_pkt_count, 32'd21);
    check("t4_ovf", cap_overflow, 1'b1);
    check("t4_head", cap_rd_data, {16'd1, 128'd200});

    clr_pulse();
    check("clr_pkt", stat_pkt_count, 32'd0);
    check("clr_beat", stat_beat_count, 32'd0);
    check("clr_byte", stat_byte_count, 48'd0);
    check("clr_ovf", cap_overflow, 1'b0);
    check("clr_fifo_kept", cap_rd_data, {16'd1, 128'd200});

    // Push and pop together on a full FIFO.
    cap_rd_en = 1'b1;
    beat(256'h77, 32'h0000_00ff, U5, 1'b1);
    cap_rd_en = 1'b0;
    check("t5_ovf", cap_overflow, 1'b0);
    check("t5_pkt", stat_pkt_count, 32'd1);
    for (int i = 1; i < DEPTH; i++) begin
      check("t5_order", cap_rd_data, {LW'(i + 1), UW'(i + 200)});
      rd_pulse();
    end
    check("t5_last", cap_rd_data, {16'd8, U5});
    rd_pulse();
    check("t5_drained", cap_empty, 1'b1);

    // Length saturation: 2050 beats of 32 bytes.
    for (int i = 0; i < 2050; i++) begin
      beat(DW'(i), '1, U6, (i == 2049));
    end
    check("sat_len", cap_rd_data, {16'hffff, U6});
    rd_pulse();

    // Source withdraws tvalid while stalled.
    cfg_stall_period = 8'd1;
    idle(260);
    check("stall_tready_low", s_axis_tready, 1'b0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 256'hdead; s_axis_tstrb = '1; s_axis_tlast = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    step();
    check("proto_drop", proto_err, PCHK);
    check("proto_no_beats", stat_beat_count, 32'd2051);
    cfg_stall_period = 8'd0;
    clr_pulse();
    check("proto_cleared", proto_err, 1'b0);

    // Zero-strobe beat.
    beat(256'h0, '0, U7, 1'b1);
    check("zero_strb_perr", proto_err, PCHK);
    check("zero_strb_head", cap_rd_data, {16'd0, U7});
    rd_pulse();
    clr_pulse();

    // Reset in the middle of a packet.
    beat(256'h8, '1, U8, 1'b1);
    beat(256'h9, '1, U9, 1'b0);
    areset = 1'b1;
    idle(2);
    areset = 1'b0;
    check("mid_rst_empty", cap_empty, 1'b1);
    check("mid_rst_pkt", stat_pkt_count, 32'd0);
    check("mid_rst_rd", cap_rd_data, '0);
    step();
    beat(256'ha, 32'h0000_00ff, U10, 1'b1);
    check("mid_rst_new_head", cap_rd_data, {16'd8, U10});
    check("mid_rst_pkt_after", stat_pkt_count, 32'd1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nf10_axis_capture_sink.md
Name: nf10_axis_capture_sink

Overview:
- Parametrised, synthesizable AXI4-Stream sink and recorder for 10G datapath benches and on-chip debug.
- Accepts any output-queue port, with programmable tready back-pressure.
- Keeps packet, beat and byte statistics.
- Stores the first-beat tuser and byte length of each packet in an internal capture FIFO that a local reader drains.

Parameters:
C_S_AXIS_DATA_WIDTH, 256, tdata width in bits (multiple of 8, ≥64)
C_S_AXIS_TUSER_WIDTH, 128, tuser width in bits
C_FIFO_DEPTH, 16, capture FIFO entries (power of 2, ≥2)
C_LEN_WIDTH, 16, packet byte-length field width; saturating

Ports:
aclk  in  1  clock, all logic rising-edge
areset  in  1  asynchronous active-high reset
s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  stream data
s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte strobes
s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband; valid on first beat
s_axis_tvalid  in  1  source valid
s_axis_tready  out  1  sink ready (registered)
s_axis_tlast  in  1  last beat of packet
cfg_stall_period  in  8  0 = always ready; N>0 = tready low 1 cycle in every N
stat_clear  in  1  synchronous clear of counters and sticky flags
stat_pkt_count  out  32  completed packets (wraps)
stat_beat_count  out  32  accepted beats (wraps)
stat_byte_count  out  48  accepted bytes (wraps)
cap_rd_en  in  1  pop head entry
cap_rd_data  out  C_LEN_WIDTH+C_S_AXIS_TUSER_WIDTH  {len, tuser}; head entry
cap_empty  out  1  FIFO empty
cap_overflow  out  1  sticky: an entry was dropped
proto_err  out  1  sticky AXIS protocol violation

Behaviour:
- Reset values: tready=0, all counters 0, cap_empty=1, cap_overflow=0, proto_err=0, FSM=IDLE, cap_rd_data=0.
- Handshake: a beat is accepted in any cycle with tvalid&&tready.
- Throttle counter (8 bits) increments each cycle. It wraps to 0 on reaching cfg_stall_period-1.
- Next tready = !(cfg_stall_period!=0 && cnt==cfg_stall_period-1).
- With cfg_stall_period=1, tready is permanently 0. This is legal, used for stall tests.
- The first cycle after reset deassertion has tready=0. tready=1 from the second cycle when cfg_stall_period=0.
- Beat bytes = popcount(tstrb). Per-packet length accumulates beat bytes and saturates at 2^C_LEN_WIDTH-1.
- FSM IDLE:
  - An accepted beat latches tuser and loads len=popcount.
  - If tlast, the packet completes immediately and the FSM stays IDLE.
  - Otherwise the FSM goes to IN_PKT.
- FSM IN_PKT:
  - Accepted beats add to len.
  - An accepted beat with tlast completes the packet and returns to IDLE.
- Packet completion: stat_pkt_count+1 and push of {final len, latched tuser}.
- Stats update one cycle after the handshake.
- The capture FIFO is first-word-fall-through:
  - cap_rd_data shows the head combinationally from storage.
  - cap_rd_en while !cap_empty pops.
  - cap_rd_en while empty is ignored.
- Pointers are log2(C_FIFO_DEPTH)+1 bits; full = MSBs differ and the rest are equal.
- Push while full without a same-cycle pop: entry dropped, cap_overflow=1, counters still update.
- Push while full with a same-cycle pop: both happen and occupancy is unchanged.
- stat_clear:
  - Zeroes the counters and sticky flags next cycle.
  - Has priority over a same-cycle increment.
  - Leaves the FIFO contents and FSM untouched.
- areset mid-packet: the FSM returns to IDLE, the partial packet is discarded, and the FIFO is emptied.

Optional Feature:
- Macro NF10_AXIS_CAPTURE_PROTOCOL_CHECK_EN.
- Defined:
  - Registers a stalled flag, set when tvalid&&!tready.
  - In the cycle after a stall, proto_err is set (sticky) if tvalid falls or tdata/tstrb/tuser/tlast change.
  - proto_err is also set if tstrb==0 on an accepted beat.
- Undefined: proto_err is tied 0 and no comparison registers exist.

Decomposition:
- Package nf10_axis_capture_pkg holds:
  - FSM state typedef (IDLE, IN_PKT);
  - popcount function;
  - width constants for counters (32/32/48);
  - the capture-entry struct {len, tuser}.
- One sub-module, nf10_capture_fifo: a parametrised FWFT FIFO with push/pop/full/empty and drop-on-full.

Test Plan:
- Single 64B packet, 2 beats with full strobes at 256b, cfg_stall_period=0:
  - expected: pkt=1, beat=2, byte=64;
  - expected FIFO head {64, tuser of beat 0}.
- 1-beat packet with tstrb=0x0000_000F and tlast -> entry len=4; FSM stays IDLE; byte_count=4.
- cfg_stall_period=4 with continuous tvalid for 40 cycles -> tready low on every 4th cycle; 30 beats accepted; no beats lost.
- C_FIFO_DEPTH+2 one-beat packets without reads:
  - expected: pkt_count=C_FIFO_DEPTH+2 and cap_overflow=1;
  - the FIFO holds the first C_FIFO_DEPTH entries in order.
- Full FIFO with simultaneous push and pop -> occupancy unchanged, no overflow; then stat_clear pulse -> counters 0, cap_overflow 0, FIFO intact.
- Protocol check (macro defined): source drops tvalid while tready=0 -> proto_err=1 next cycle; with the macro undefined it stays 0.
